rr_packet_selector: RTL and testbench
=====================================

Name: rr_packet_selector

Overview:
- Parametrised, registered successor to the combinational one-hot AND-OR selector.
- Arbitrates CH_NUM valid/ready input channels with round-robin fairness and holds the grant until a packet's last beat is accepted.
- Forwards the granted channel through a one-hot AND-OR mux into a single registered output stage.
- Sits between multiple stream producers and one shared consumer.

Parameters:
- DATA_W, 2: data width per channel, in bits; must be at least 1.
- CH_NUM, 4: number of input channels; must be at least 1.
- PTR_W, max(1, clog2(CH_NUM)): width of the round-robin pointer. Derived; do not override.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: reset. Synchronous, active-high.
- in_data, input, DATA_W*CH_NUM: packed channel data; channel i occupies bits [(i+1)*DATA_W-1 : i*DATA_W].
- in_valid, input, CH_NUM: per-channel valid.
- in_last, input, CH_NUM: per-channel last-beat marker, qualified by in_valid.
- in_ready, output, CH_NUM: per-channel ready.
- out_data, output, DATA_W: registered output data.
- out_valid, output, 1: registered output valid.
- out_last, output, 1: registered last-beat marker.
- out_ready, input, 1: downstream ready.
- grant, output, CH_NUM: registered one-hot grant of the channel that owns the output; all-zero when idle.
- busy, output, 1: high while in state LOCK.

Behaviour:
- Reset: while rst is high at a clock edge, the block loads out_valid=0, out_last=0, out_data=0, grant=0, ptr=0, state=IDLE.
  - Reset mid-packet discards the held beat and any partial packet; no beat is emitted afterwards.
- FSM, two states:
  - IDLE: if any in_valid bit is set, select the first set bit searching from index ptr upward with wrap-around (ptr, ptr+1, …, CH_NUM-1, 0, …, ptr-1). Register its one-hot value into grant and go to LOCK. If no bit is set, stay in IDLE with grant=0.
  - LOCK: remain until the granted channel transfers a beat with in_last=1. On that transfer:
    - grant is cleared to 0;
    - ptr becomes (granted index + 1) mod CH_NUM;
    - state goes to IDLE.
- Arbitration cost: one dead cycle in IDLE per packet. The first beat reaches out_valid 2 cycles after in_valid rises, when out_ready is held high.
- Ready: in_ready[i] = grant[i] & (~out_valid | out_ready). This is combinational from registered state and out_ready. Non-granted channels always see in_ready=0.
- Input transfer: occurs when in_valid[i] & in_ready[i]. out_data loads the AND-OR of in_data masked by grant, and out_last loads in_last[g]. out_valid becomes 1.
- Output transfer: occurs when out_valid & out_ready. If no input transfer happens in the same cycle, out_valid becomes 0. A simultaneous input and output transfer keeps out_valid=1 and loads new data, giving full throughput of 1 beat per cycle within a packet.
- Stability: while out_valid=1 and out_ready=0, out_data, out_valid and out_last hold unchanged.
- Granted channel drops in_valid mid-packet: the grant is held indefinitely. There is no timeout and no transfer occurs.
- Changes on non-granted in_valid bits during LOCK have no effect.
- Single-beat packet: in_last=1 on the first beat locks and releases in the same LOCK cycle.
- CH_NUM=1: ptr stays 0; the block degenerates to a registered stage with a 1-cycle arbitration gap between packets.
- Width rule: out_data is exactly DATA_W bits. No extension or truncation is performed.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs active → out_valid=0, out_data=0, grant=0, busy=0, in_ready=0.
- Single channel, CH_NUM=4, DATA_W=8: ch2 sends 3 beats 0x11, 0x22, 0x33 with last on 0x33; out_ready=1 → grant=0b0100 one cycle after in_valid, out_valid from cycle 2, beats in order, out_last only on 0x33, then grant=0 and ptr=3.
- Round-robin fairness: all four channels send continuous single-beat packets (data = channel index) → grant order ch0, ch1, ch2, ch3, ch0; each beat appears exactly once.
- Lock hold: ch1 is granted with a 4-beat packet and ch0 asserts valid mid-packet → ch0 in_ready stays 0 until ch1's last beat is accepted; ch0 is granted next (pointer wraps from 2 to 0).
- Backpressure: hold out_ready=0 for 5 cycles during a packet → out_data, out_valid and out_last are stable, in_ready[g]=0 after the first held beat, and no beat is lost or duplicated once out_ready returns to 1.
- Reset mid-packet: pulse rst during beat 2 of a 4-beat ch3 packet → the next cycle shows out_valid=0, grant=0, ptr=0, and the next arbitration starts from ch0.

Source files
------------

// File: rtl/rr_packet_selector.sv
// rr_packet_selector
//   Round-robin packet arbiter with a registered one-hot AND-OR output stage.
//   Up to CH_NUM valid/ready producers share one consumer. A grant is held
//   until the granted channel's last beat is accepted, then the round-robin
//   pointer moves past the winner.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    packed channel data, channel i at [(i+1)*DATA_W-1 : i*DATA_W]
//   in_valid   per-channel valid
//   in_last    per-channel last-beat marker (qualified by in_valid)
//   in_ready   per-channel ready (only the granted channel can see 1)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_last   registered output last-beat marker
//   out_ready  downstream ready
//   grant      registered one-hot grant, all-zero when idle
//   busy       high while a packet holds the grant
module rr_packet_selector #(
   parameter int DATA_W = 2,
   parameter int CH_NUM = 4,
   parameter int PTR_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W*CH_NUM-1:0] in_data,
   input  logic [CH_NUM-1:0]        in_valid,
   input  logic [CH_NUM-1:0]        in_last,
   output logic [CH_NUM-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic [CH_NUM-1:0]        grant,
   output logic                     busy
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [PTR_W-1:0]    ptr, ptr_nxt;
   logic [CH_NUM-1:0]   grant_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic                valid_nxt;
   logic                last_nxt;

   logic [DATA_W-1:0]   mux_data;
   logic                mux_last;
   logic [CH_NUM-1:0]   pick;
   logic [PTR_W-1:0]    gidx;
   logic                in_xfer;
   logic                out_xfer;

   // The output register can take a new beat when empty or draining this cycle.
   assign in_ready = grant & {CH_NUM{~out_valid | out_ready}};
   assign busy     = (state == LOCK);
   assign in_xfer  = |(in_valid & in_ready);
   assign out_xfer = out_valid & out_ready;

   // One-hot AND-OR mux of the granted channel.
   always_comb begin
      mux_data = '0;
      mux_last = 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         mux_data = mux_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
         mux_last = mux_last | (in_last[i] & grant[i]);
      end
   end

   // First requester at or after ptr, wrapping around.
   always_comb begin
      int unsigned c;
      c    = 0;
      pick = '0;
      for (int unsigned k = 0; k < CH_NUM; k++) begin
         c = 32'(ptr) + k;
         if (c >= CH_NUM) c = c - CH_NUM;
         if ((pick == '0) && in_valid[c]) pick[c] = 1'b1;
      end
   end

   // Index of the current grant, used to advance the pointer on release.
   always_comb begin
      gidx = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (grant[i]) gidx = PTR_W'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      data_nxt  = out_data;
      last_nxt  = out_last;
      valid_nxt = out_valid;

      if (out_xfer) valid_nxt = 1'b0;
      if (in_xfer) begin
         data_nxt  = mux_data;
         last_nxt  = mux_last;
         valid_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (|in_valid) begin
               grant_nxt = pick;
               state_nxt = LOCK;
            end else begin
               grant_nxt = '0;
            end
         end
         LOCK: begin
            if (in_xfer && mux_last) begin
               grant_nxt = '0;
               state_nxt = IDLE;
               ptr_nxt   = (32'(gidx) == CH_NUM - 1) ? '0 : gidx + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         grant     <= grant_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
      end
   end

endmodule

// File: tb/tb_rr_packet_selector.sv
// tb_rr_packet_selector
//   Self-checking bench for rr_packet_selector (CH_NUM=4, DATA_W=8).
//   Beats carry {channel, sequence} so ordering and fairness are visible in
//   the data itself. A packet-level reference arbiter predicts which beats are
//   accepted; a separate monitor pops predictions as the DUT emits beats.
module tb_rr_packet_selector;

   localparam int CH = 4;
   localparam int DW = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [DW*CH-1:0] in_data;
   logic [CH-1:0]    in_valid;
   logic [CH-1:0]    in_last;
   logic [CH-1:0]    in_ready;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;
   logic [CH-1:0]    grant;
   logic             busy;

   rr_packet_selector #(.DATA_W(DW), .CH_NUM(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- stimulus state ----------------
   bit          active [CH];
   bit          stall  [CH];
   int unsigned rem    [CH];
   int unsigned seq    [CH];
   logic [CH-1:0] accm;
   int          hold_lo = 0;

   function automatic logic [DW-1:0] beat(input int c, input int unsigned s);
      logic [DW-1:0] b;
      b = DW'((c << 6) | int'(s & 63));
      return b;
   endfunction

   task automatic drive();
      for (int c = 0; c < CH; c++) begin
         in_valid[c]           = active[c] && !stall[c];
         in_last[c]            = (rem[c] == 1);
         in_data[c*DW +: DW]   = beat(c, seq[c]);
      end
   endtask

   task automatic start_pkt(input int c, input int unsigned len);
      active[c] = 1'b1;
      rem[c]    = len;
   endtask

   // One clock: note which channels handshake, then advance them after the edge.
   task automatic step();
      @(negedge clk);
      accm = in_valid & in_ready;
      @(posedge clk);
      #2;
      for (int c = 0; c < CH; c++) begin
         if (accm[c] && active[c]) begin
            seq[c]++;
            rem[c]--;
            if (rem[c] == 0) active[c] = 1'b0;
         end
      end
      drive();
   endtask

   task automatic drain(input string name);
      bit idle;
      idle = 1'b0;
      for (int c = 0; c < CH; c++) stall[c] = 1'b0;
      out_ready = 1'b1;
      drive();
      for (int n = 0; n < 300 && !idle; n++) begin
         step();
         idle = !out_valid && !busy;
         for (int c = 0; c < CH; c++) if (active[c]) idle = 1'b0;
      end
      chk({name, "_idle"}, 32'(idle), 32'd1);
      chk({name, "_sb_empty"}, expq.size(), 0);
   endtask

   // ---------------- reference model ----------------
   // Packet-level arbiter: owner channel (-1 idle), round-robin start point,
   // and whether one accepted beat is waiting at the output.
   int            owner = -1;
   int            rr    = 0;
   bit            full  = 1'b0;
   logic [DW:0]   expq[$];

   initial forever begin
      bit acc, outx;
      @(posedge clk);
      if (rst) begin
         owner = -1;
         rr    = 0;
         full  = 1'b0;
         expq.delete();
      end else begin
         acc  = 1'b0;
         outx = full && out_ready;
         if (owner >= 0) begin
            if (in_valid[owner] && (!full || out_ready)) begin
               acc = 1'b1;
               expq.push_back({in_last[owner], in_data[owner*DW +: DW]});
               full = 1'b1;
               if (in_last[owner]) begin
                  rr    = (owner + 1) % CH;
                  owner = -1;
               end
            end
         end else if (in_valid != '0) begin
            for (int k = 0; k < CH; k++) begin
               if (in_valid[(rr + k) % CH]) begin
                  owner = (rr + k) % CH;
                  break;
               end
            end
         end
         if (outx && !acc) full = 1'b0;
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial forever begin
      logic [DW:0] e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (expq.size() == 0) begin
            chk("sb_pending", expq.size(), 1);
         end else begin
            e = expq.pop_front();
            chk("sb_data", 32'(out_data), 32'(e[DW-1:0]));
            chk("sb_last", 32'(out_last), 32'(e[DW]));
         end
      end
   end

   // ---------------- per-cycle handshake / stability checks ----------------
   bit            hold_pend = 1'b0;
   logic [DW-1:0] h_data;
   logic          h_last;

   initial forever begin
      @(negedge clk);
      chk("grant", 32'(grant), (owner >= 0) ? (32'd1 << owner) : 32'd0);
      chk("busy", 32'(busy), 32'(owner >= 0));
      chk("out_valid", 32'(out_valid), 32'(full));
      chk("in_ready", 32'(in_ready),
          (owner >= 0 && (!full || out_ready)) ? (32'd1 << owner) : 32'd0);
      if (hold_pend) begin
         chk("hold_data", 32'(out_data), 32'(h_data));
         chk("hold_last", 32'(out_last), 32'(h_last));
      end
      hold_pend = out_valid && !out_ready && !rst;
      h_data    = out_data;
      h_last    = out_last;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int c = 0; c < CH; c++) begin
         active[c] = 1'b0;
         stall[c]  = 1'b0;
         rem[c]    = 0;
         seq[c]    = 0;
      end
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < CH; c++) start_pkt(c, 1);
      drive();

      // Reset with every input active.
      repeat (2) @(posedge clk);
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int c = 0; c < CH; c++) active[c] = 1'b0;
      drive();

      // Single 3-beat packet on ch2.
      start_pkt(2, 3);
      drive();
      step(); #1;
      chk("ch2_grant", 32'(grant), 32'b0100);
      chk("ch2_no_out_yet", 32'(out_valid), 0);
      step(); #1;
      chk("ch2_first_valid", 32'(out_valid), 1);
      chk("ch2_first_data", 32'(out_data), 32'(beat(2, 0)));
      chk("ch2_first_last", 32'(out_last), 0);
      step(); step(); #1;
      chk("ch2_last_data", 32'(out_data), 32'(beat(2, 2)));
      chk("ch2_last_flag", 32'(out_last), 1);
      chk("ch2_released", 32'(grant), 0);

      // Pointer now at 3: ch3 must beat ch0.
      start_pkt(0, 1);
      start_pkt(3, 1);
      drive();
      step(); #1;
      chk("ptr3_grant", 32'(grant), 32'b1000);
      drain("dir");

      // Reset during beat 2 of a 4-beat ch3 packet.
      start_pkt(3, 4);
      drive();
      step(); step(); step(); #1;
      rst = 1'b1;
      step(); #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_grant", 32'(grant), 0);
      chk("midrst_busy", 32'(busy), 0);
      rst = 1'b0;
      for (int c = 0; c < CH; c++) active[c] = 1'b0;
      drive();
      step();
      start_pkt(0, 1);
      start_pkt(3, 1);
      drive();
      step(); #1;
      chk("midrst_ptr0", 32'(grant), 32'b0001);
      drain("rst");

      // Randomized traffic with input gaps and output backpressure bursts.
      for (int n = 0; n < 2500; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (!active[c] && ($urandom % 3 == 0)) start_pkt(c, $urandom_range(1, 4));
            stall[c] = active[c] && ($urandom % 8 == 0);
         end
         if (hold_lo == 0 && ($urandom % 40 == 0)) hold_lo = 5;
         if (hold_lo > 0) begin
            out_ready = 1'b0;
            hold_lo--;
         end else begin
            out_ready = ($urandom % 4 != 0);
         end
         drive();
         step();
      end
      drain("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
